// File: rtl/uart_tx_framer_if.sv
// Parallel-in / serial-out bundle for the UART transmit framer.
// The master side supplies words and frame options; the slave side drives the line.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            prescale;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        output prescale,
        input  TX_OUT,
        input  busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        input  prescale,
        output TX_OUT,
        output busy
    );

endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Each bit lasts the captured prescale in clk cycles; TX_OUT and busy are registered.
module uart_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_framer_if.slave  bus
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [5:0]            per_q, per_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic       last_tick;
    logic       parity_bit;
    logic [5:0] per_in;

    // Bit period minus one; a prescale of zero behaves like one cycle per bit.
    assign per_in     = (bus.prescale == 6'd0) ? 6'd0 : bus.prescale - 6'd1;
    assign last_tick  = (cnt_q == 6'd0);
    assign parity_bit = (^data_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        per_d     = per_q;

        unique case (state_q)
            StIdle: begin
                if (bus.DATA_VALID) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    per_d     = per_in;
                    cnt_d     = per_in;
                    bit_idx_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (last_tick) begin
                    state_d   = StData;
                    cnt_d     = per_q;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            StData: begin
                if (last_tick) begin
                    cnt_d = per_q;
                    if (bit_idx_q == LastIdx) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            StParity: begin
                if (last_tick) begin
                    state_d = StStop;
                    cnt_d   = per_q;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            StStop: begin
                if (last_tick) begin
                    state_d = StIdle;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 6'd0;
            end
        endcase

        // Outputs are registered from the next state so the line changes on the same edge.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_idx_d];
            StParity: tx_d = parity_bit;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            per_q     <= 6'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            per_q     <= per_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: stimulus queues hand-written frames,
// a negedge monitor checks the line bit by bit, busy length and idle level.
module tb_uart_tx_framer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_framer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_framer #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected frames: line bits in transmit order, cycles per bit, busy length.
    string exp_bits_q[$];
    int    exp_p_q[$];
    int    exp_busy_q[$];

    bit    mon_en     = 1'b0;
    bit    in_frame   = 1'b0;
    bit    have_exp   = 1'b0;
    bit    frame_bad  = 1'b0;
    int    cyc        = 0;
    int    idle_run   = 0;
    int    gap_before = 0;
    int    bad_cyc    = 0;
    logic  bad_act;
    logic  bad_exp;
    string cur_bits;
    int    cur_p      = 1;
    int    cur_busy   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input string bits, input int p, input int busy_cycles);
        exp_bits_q.push_back(bits);
        exp_p_q.push_back(p);
        exp_busy_q.push_back(busy_cycles);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.prescale   = ps;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (bus.busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy !== level) begin
            bad++;
            $display("FAIL %s: busy still %b after %0d cycles, wanted %b",
                     name, bus.busy, limit, level);
        end
    endtask

    always @(negedge clk) begin
        int  idx;
        logic exp_bit;
        if (mon_en) begin
            if (bus.busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    cyc        = 0;
                    frame_bad  = 1'b0;
                    gap_before = idle_run;
                    if (exp_bits_q.size() == 0) begin
                        have_exp = 1'b0;
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: busy rose with got 1 expected 0 frames pending");
                    end else begin
                        have_exp = 1'b1;
                        cur_bits = exp_bits_q.pop_front();
                        cur_p    = exp_p_q.pop_front();
                        cur_busy = exp_busy_q.pop_front();
                    end
                end
                if (have_exp) begin
                    idx     = cyc / cur_p;
                    exp_bit = (idx < cur_bits.len()) ? (cur_bits[idx] == "1") : 1'b1;
                    if (bus.TX_OUT !== exp_bit && !frame_bad) begin
                        frame_bad = 1'b1;
                        bad_cyc   = cyc;
                        bad_act   = bus.TX_OUT;
                        bad_exp   = exp_bit;
                    end
                end
                cyc++;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    idle_run = 0;
                    if (have_exp) begin
                        total++;
                        if (frame_bad) begin
                            bad++;
                            $display("FAIL frame %s: cycle %0d TX_OUT got %b expected %b",
                                     cur_bits, bad_cyc, bad_act, bad_exp);
                        end
                        total++;
                        if (cyc != cur_busy) begin
                            bad++;
                            $display("FAIL busy_len %s: got %0d expected %0d",
                                     cur_bits, cyc, cur_busy);
                        end
                    end
                end
                idle_run++;
                total++;
                if (bus.TX_OUT !== 1'b1) begin
                    bad++;
                    $display("FAIL idle_tx: got %b expected 1", bus.TX_OUT);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = 6'd8;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", 32'(bus.TX_OUT), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        mon_en = 1'b1;

        // 0xA5, no parity, 8 cycles per bit
        expect_frame("0101001011", 8, 80);
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        wait_busy(1'b0, 200, "a5_nopar");

        // 0xA5 even then odd parity, 16 cycles per bit
        expect_frame("01010010101", 16, 176);
        send(8'hA5, 1'b1, 1'b0, 6'd16);
        wait_busy(1'b0, 400, "a5_even");
        expect_frame("01010010111", 16, 176);
        send(8'hA5, 1'b1, 1'b1, 6'd16);
        wait_busy(1'b0, 400, "a5_odd");

        // prescale 0 acts as one cycle per bit
        expect_frame("01110000011", 1, 11);
        send(8'h07, 1'b1, 1'b0, 6'd0);
        wait_busy(1'b0, 40, "p0");

        // reset wins over a simultaneous request
        @(negedge clk);
        rst            = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.DATA_VALID = 1'b0;
        check("rst_prio_busy", 32'(bus.busy), 32'd0);
        check("rst_prio_tx", 32'(bus.TX_OUT), 32'd1);

        // request and input changes during a frame are ignored
        expect_frame("0101010101", 4, 40);
        send(8'h55, 1'b0, 1'b0, 6'd4);
        repeat (9) @(negedge clk);
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        bus.prescale   = 6'd1;
        bus.DATA_VALID = 1'b1;
        repeat (3) @(negedge clk);
        bus.DATA_VALID = 1'b0;
        wait_busy(1'b0, 100, "ignore_55");
        repeat (20) @(negedge clk);
        check("no_late_frame", 32'(bus.busy), 32'd0);
        expect_frame("00011110011", 3, 33);
        send(8'h3C, 1'b1, 1'b1, 6'd3);
        wait_busy(1'b0, 100, "resend_3c");

        // reset in the middle of data bit 3 (second of its four cycles)
        repeat (3) @(negedge clk);
        expect_frame("01010", 4, 18);
        send(8'h55, 1'b0, 1'b0, 6'd4);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_tx", 32'(bus.TX_OUT), 32'd1);
        repeat (3) @(negedge clk);
        expect_frame("0100000011", 2, 20);
        send(8'h81, 1'b0, 1'b0, 6'd2);
        wait_busy(1'b0, 100, "after_abort_81");

        // DATA_VALID held high: exactly one idle cycle between frames
        repeat (3) @(negedge clk);
        expect_frame("0010010001", 8, 80);
        expect_frame("0001011001", 8, 80);
        bus.P_DATA     = 8'h12;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = 6'd8;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        wait_busy(1'b1, 5, "b2b_start1");
        bus.P_DATA = 8'h34;
        wait_busy(1'b0, 200, "b2b_end1");
        wait_busy(1'b1, 5, "b2b_start2");
        bus.DATA_VALID = 1'b0;
        wait_busy(1'b0, 200, "b2b_end2");
        @(negedge clk);
        check("b2b_gap", 32'(gap_before), 32'd1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_bits_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
